// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line, read-only instruction cache
module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        valid_from_if,
    input  logic [31:0] addr_from_if,
    output logic        ready_to_if,
    output logic        valid_to_if,
    output logic [31:0] inst_to_if,
    output logic        valid_to_memctrl,
    output logic [31:0] addr_to_memctrl,
    input  logic        valid_from_memctrl,
    input  logic [31:0] data_from_memctrl
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;
    typedef enum logic [1:0] {IDLE, MISS, DROP} state_t;
    state_t state;
    logic [LINES-1:0] valid_bits;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0] data [LINES];
    logic [29:0] req_addr;
    logic [31:0] word_addr;
    logic [INDEX_BITS-1:0] a_idx, r_idx;
    logic accept, hit, fill;
    assign ready_to_if = state == IDLE;
    assign word_addr = addr_from_if & ~32'd3;
    assign a_idx = word_addr[INDEX_BITS+1:2];
    assign r_idx = req_addr[INDEX_BITS-1:0];
    assign accept = rdy & valid_from_if & ready_to_if & ~clear;
    assign hit = valid_bits[a_idx] && tags[a_idx] == word_addr[31:INDEX_BITS+2];
    assign fill = rdy & ~rst & (state != IDLE) & valid_from_memctrl;
    // Tag and data arrays are not reset; valid_bits alone gates hits.
    always_ff @(posedge clk) begin
        if (fill) begin
            tags[r_idx] <= req_addr[29:INDEX_BITS];
            data[r_idx] <= data_from_memctrl;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            valid_bits <= '0;
            req_addr <= '0;
            valid_to_if <= 1'b0;
            inst_to_if <= '0;
            valid_to_memctrl <= 1'b0;
            addr_to_memctrl <= '0;
        end else if (rdy) begin
            valid_to_if <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    req_addr <= word_addr[31:2];
                    if (hit) begin
                        valid_to_if <= 1'b1;
                        inst_to_if <= data[a_idx];
                    end else begin
                        state <= MISS;
                        valid_to_memctrl <= 1'b1;
                        addr_to_memctrl <= word_addr;
                    end
                end
            end else if (valid_from_memctrl) begin
                // A fill always installs; only a still-owed MISS answers IF.
                valid_bits[r_idx] <= 1'b1;
                valid_to_memctrl <= 1'b0;
                state <= IDLE;
                if (state == MISS && !clear) begin
                    valid_to_if <= 1'b1;
                    inst_to_if <= data_from_memctrl;
                end
            end else if (clear) begin
                state <= DROP;
            end
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scenarios plus randomized traffic against a line-level cache model
module tb_icache;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        valid_from_if = 1'b0;
    logic [31:0] addr_from_if = '0;
    logic        ready_to_if;
    logic        valid_to_if;
    logic [31:0] inst_to_if;
    logic        valid_to_memctrl;
    logic [31:0] addr_to_memctrl;
    logic        valid_from_memctrl = 1'b0;
    logic [31:0] data_from_memctrl = '0;
    int total = 0;
    int bad = 0;

    icache #(.INDEX_BITS(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .valid_from_if(valid_from_if), .addr_from_if(addr_from_if),
        .ready_to_if(ready_to_if), .valid_to_if(valid_to_if), .inst_to_if(inst_to_if),
        .valid_to_memctrl(valid_to_memctrl), .addr_to_memctrl(addr_to_memctrl),
        .valid_from_memctrl(valid_from_memctrl), .data_from_memctrl(data_from_memctrl)
    );

    always #5 clk = ~clk;

    // Inputs are set between edges; outputs are read 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        valid_from_if = 1'b1;
        addr_from_if = a;
        step();
        valid_from_if = 1'b0;
    endtask

    task automatic fill(input logic [31:0] d);
        valid_from_memctrl = 1'b1;
        data_from_memctrl = d;
        step();
        valid_from_memctrl = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (valid_to_if !== 1'b0) begin bad++; $display("FAIL reset_vif got=%0b exp=0", valid_to_if); end
        total++; if (inst_to_if !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", inst_to_if); end
        total++; if (valid_to_memctrl !== 1'b0) begin bad++; $display("FAIL reset_vmc got=%0b exp=0", valid_to_memctrl); end
        total++; if (addr_to_memctrl !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", addr_to_memctrl); end
        total++; if (ready_to_if !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", ready_to_if); end
    endtask

    task automatic test_cold_miss();
        fetch(32'h4);
        for (int i = 0; i < 4; i++) begin
            total++; if (valid_to_memctrl !== 1'b1 || addr_to_memctrl !== 32'h4) begin bad++; $display("FAIL cold_req cyc=%0d got=%0b/%h exp=1/00000004", i, valid_to_memctrl, addr_to_memctrl); end
            total++; if (ready_to_if !== 1'b0 || valid_to_if !== 1'b0) begin bad++; $display("FAIL cold_wait cyc=%0d ready=%0b vif=%0b exp=0/0", i, ready_to_if, valid_to_if); end
            if (i < 3) step();
        end
        fill(32'h00500093);
        total++; if (valid_to_if !== 1'b1 || inst_to_if !== 32'h00500093) begin bad++; $display("FAIL cold_resp got=%0b/%h exp=1/00500093", valid_to_if, inst_to_if); end
        total++; if (valid_to_memctrl !== 1'b0) begin bad++; $display("FAIL cold_drop got=%0b exp=0", valid_to_memctrl); end
        step();
        total++; if (valid_to_if !== 1'b0) begin bad++; $display("FAIL cold_pulse got=%0b exp=0", valid_to_if); end
    endtask

    task automatic test_back_to_back();
        valid_from_if = 1'b1;
        addr_from_if = 32'h4;
        for (int i = 0; i < 8; i++) begin
            addr_from_if = 32'h4 | 32'(i & 3);
            step();
            total++; if (valid_to_if !== 1'b1 || inst_to_if !== 32'h00500093 || valid_to_memctrl !== 1'b0) begin bad++; $display("FAIL hit_b2b cyc=%0d got=%0b/%h vmc=%0b exp=1/00500093/0", i, valid_to_if, inst_to_if, valid_to_memctrl); end
        end
        valid_from_if = 1'b0;
        step();
        total++; if (valid_to_if !== 1'b0) begin bad++; $display("FAIL hit_end got=%0b exp=0", valid_to_if); end
    endtask

    task automatic test_conflict();
        fetch(32'h104);
        total++; if (valid_to_memctrl !== 1'b1 || addr_to_memctrl !== 32'h104) begin bad++; $display("FAIL conf_req got=%0b/%h exp=1/00000104", valid_to_memctrl, addr_to_memctrl); end
        step();
        fill(32'hAAAA0104);
        total++; if (valid_to_if !== 1'b1 || inst_to_if !== 32'hAAAA0104) begin bad++; $display("FAIL conf_resp got=%0b/%h exp=1/aaaa0104", valid_to_if, inst_to_if); end
        fetch(32'h104);
        total++; if (valid_to_if !== 1'b1 || inst_to_if !== 32'hAAAA0104) begin bad++; $display("FAIL conf_rehit got=%0b/%h exp=1/aaaa0104", valid_to_if, inst_to_if); end
        fetch(32'h4);
        total++; if (valid_to_memctrl !== 1'b1 || addr_to_memctrl !== 32'h4 || valid_to_if !== 1'b0) begin bad++; $display("FAIL conf_remiss got=%0b/%h vif=%0b exp=1/00000004/0", valid_to_memctrl, addr_to_memctrl, valid_to_if); end
        fill(32'h00500093);
        total++; if (valid_to_if !== 1'b1 || inst_to_if !== 32'h00500093) begin bad++; $display("FAIL conf_resp2 got=%0b/%h exp=1/00500093", valid_to_if, inst_to_if); end
    endtask

    task automatic test_flush();
        fetch(32'h40);
        step();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (ready_to_if !== 1'b0 || valid_to_if !== 1'b0 || valid_to_memctrl !== 1'b1) begin bad++; $display("FAIL flush_wait cyc=%0d ready=%0b vif=%0b vmc=%0b exp=0/0/1", i, ready_to_if, valid_to_if, valid_to_memctrl); end
            fetch(32'h4);
        end
        fill(32'h12345678);
        total++; if (valid_to_if !== 1'b0 || ready_to_if !== 1'b1 || valid_to_memctrl !== 1'b0) begin bad++; $display("FAIL flush_fill vif=%0b ready=%0b vmc=%0b exp=0/1/0", valid_to_if, ready_to_if, valid_to_memctrl); end
        fetch(32'h40);
        total++; if (valid_to_if !== 1'b1 || inst_to_if !== 32'h12345678 || valid_to_memctrl !== 1'b0) begin bad++; $display("FAIL flush_rehit got=%0b/%h vmc=%0b exp=1/12345678/0", valid_to_if, inst_to_if, valid_to_memctrl); end
    endtask

    task automatic test_rdy_stall();
        fetch(32'h80);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fetch(32'h4);
            total++; if (valid_to_memctrl !== 1'b1 || addr_to_memctrl !== 32'h80 || ready_to_if !== 1'b0 || valid_to_if !== 1'b0) begin bad++; $display("FAIL stall_hold cyc=%0d vmc=%0b addr=%h ready=%0b vif=%0b exp=1/00000080/0/0", i, valid_to_memctrl, addr_to_memctrl, ready_to_if, valid_to_if); end
        end
        rdy = 1'b1;
        fill(32'hCAFE0080);
        total++; if (valid_to_if !== 1'b1 || inst_to_if !== 32'hCAFE0080) begin bad++; $display("FAIL stall_resp got=%0b/%h exp=1/cafe0080", valid_to_if, inst_to_if); end
        rdy = 1'b0;
        step();
        total++; if (valid_to_if !== 1'b1 || inst_to_if !== 32'hCAFE0080) begin bad++; $display("FAIL stall_freeze got=%0b/%h exp=1/cafe0080", valid_to_if, inst_to_if); end
        rdy = 1'b1;
        step();
        total++; if (valid_to_if !== 1'b0) begin bad++; $display("FAIL stall_release got=%0b exp=0", valid_to_if); end
    endtask

    task automatic test_clear_fill();
        fetch(32'hC0);
        step();
        clear = 1'b1;
        fill(32'h0BADF00D);
        clear = 1'b0;
        total++; if (valid_to_if !== 1'b0 || ready_to_if !== 1'b1 || valid_to_memctrl !== 1'b0) begin bad++; $display("FAIL clrfill vif=%0b ready=%0b vmc=%0b exp=0/1/0", valid_to_if, ready_to_if, valid_to_memctrl); end
        fetch(32'hC0);
        total++; if (valid_to_if !== 1'b1 || inst_to_if !== 32'h0BADF00D) begin bad++; $display("FAIL clrfill_hit got=%0b/%h exp=1/0badf00d", valid_to_if, inst_to_if); end
    endtask

    task automatic test_reset_mid_miss();
        fetch(32'h104);
        fill(32'hAAAA0104);
        fetch(32'h4);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (valid_to_memctrl !== 1'b0 || addr_to_memctrl !== 32'h0 || valid_to_if !== 1'b0 || ready_to_if !== 1'b1) begin bad++; $display("FAIL rstmiss vmc=%0b addr=%h vif=%0b ready=%0b exp=0/0/0/1", valid_to_memctrl, addr_to_memctrl, valid_to_if, ready_to_if); end
        fill(32'hDEADBEEF);
        total++; if (valid_to_if !== 1'b0 || valid_to_memctrl !== 1'b0) begin bad++; $display("FAIL rstmiss_stray vif=%0b vmc=%0b exp=0/0", valid_to_if, valid_to_memctrl); end
        fetch(32'h4);
        total++; if (valid_to_memctrl !== 1'b1 || addr_to_memctrl !== 32'h4 || valid_to_if !== 1'b0) begin bad++; $display("FAIL rstmiss_refetch vmc=%0b addr=%h vif=%0b exp=1/00000004/0", valid_to_memctrl, addr_to_memctrl, valid_to_if); end
        fill(32'h00500093);
        total++; if (valid_to_if !== 1'b1 || inst_to_if !== 32'h00500093) begin bad++; $display("FAIL rstmiss_resp got=%0b/%h exp=1/00500093", valid_to_if, inst_to_if); end
    endtask

    // Model: each of the 64 lines remembers which word it holds; a miss is an
    // outstanding word fetch that may or may not still be owed to IF.
    task automatic test_random();
        bit          line_ok [64];
        logic [29:0] line_word [64];
        logic [31:0] line_data [64];
        bit          pend = 0;
        bit          owed = 0;
        logic [29:0] pend_word = '0;
        int          wait_cnt = 0;
        bit          exp_vif = 0;
        logic [31:0] exp_inst = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) line_ok[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            int li;
            rdy = ($urandom % 8) != 0;
            clear = ($urandom % 12) == 0;
            valid_from_if = $urandom % 2;
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            addr_from_if = a;
            valid_from_memctrl = rdy && ((pend && wait_cnt == 0) || (!pend && ($urandom % 20) == 0));
            data_from_memctrl = $urandom;
            if (rdy) begin
                exp_vif = 0;
                if (!pend) begin
                    if (valid_from_if && !clear) begin
                        li = (a / 4) % 64;
                        if (line_ok[li] && line_word[li] == a[31:2]) begin
                            exp_vif = 1;
                            exp_inst = line_data[li];
                        end else begin
                            pend = 1;
                            owed = 1;
                            pend_word = a[31:2];
                            wait_cnt = $urandom_range(1, 5);
                        end
                    end
                end else if (valid_from_memctrl) begin
                    li = pend_word % 64;
                    line_ok[li] = 1;
                    line_word[li] = pend_word;
                    line_data[li] = data_from_memctrl;
                    pend = 0;
                    if (owed && !clear) begin
                        exp_vif = 1;
                        exp_inst = data_from_memctrl;
                    end
                end else begin
                    if (clear) owed = 0;
                    if (wait_cnt > 0) wait_cnt--;
                end
            end
            step();
            total++; if (valid_to_if !== exp_vif || (exp_vif && inst_to_if !== exp_inst)) begin bad++; $display("FAIL rand_resp cyc=%0d got=%0b/%h exp=%0b/%h", c, valid_to_if, inst_to_if, exp_vif, exp_inst); end
            total++; if (valid_to_memctrl !== pend || (pend && addr_to_memctrl !== {pend_word, 2'b00}) || ready_to_if !== !pend) begin bad++; $display("FAIL rand_req cyc=%0d vmc=%0b addr=%h ready=%0b exp=%0b/%h/%0b", c, valid_to_memctrl, addr_to_memctrl, ready_to_if, pend, {pend_word, 2'b00}, !pend); end
        end
        rdy = 1'b1;
        clear = 1'b0;
        valid_from_if = 1'b0;
        valid_from_memctrl = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_flush();
        test_rdy_stall();
        test_clear_fill();
        test_reset_mid_miss();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the instruction fetcher (IF) and the memory controller's icache port. It answers IF fetch requests from a one-word-per-line store. On a miss it issues a level-held request to the memory controller, installs the returned word, and forwards it to IF. A ROB-driven `clear` discards the pending response without corrupting the cache.

## Interface
- `INDEX_BITS`, default 6: number of lines = 2^INDEX_BITS; index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2]; addr[1:0] ignored.
- `clk` input 1: single clock, posedge.
- `rst` input 1: reset, synchronous, active-high.
- `rdy` input 1: global enable; low freezes all state and outputs.
- `clear` input 1: mispredict flush from ROB.
- `valid_from_if` input 1: fetch request strobe.
- `addr_from_if` input 32: fetch PC.
- `ready_to_if` output 1: combinational, high iff state == IDLE.
- `valid_to_if` output 1: one-cycle response pulse.
- `inst_to_if` output 32: instruction word, valid while `valid_to_if` is high.
- `valid_to_memctrl` output 1: miss request, level-held.
- `addr_to_memctrl` output 32: miss address, word-aligned (addr[1:0] = 0).
- `valid_from_memctrl` input 1: one-cycle fill-done pulse.
- `data_from_memctrl` input 32: fill word, sampled with `valid_from_memctrl`.

## Operation
- Storage: `tag[2^INDEX_BITS]`, `data[2^INDEX_BITS]`, and a `valid` bit vector. All valid bits clear in the reset cycle. Tag and data are not reset.
- States:
  - IDLE: accepts requests.
  - MISS: waiting for fill; response owed to IF.
  - DROP: waiting for fill; response cancelled.
- Acceptance: a request is accepted only when `rdy & valid_from_if & ready_to_if & !clear`. Any other request is ignored with no side effects. The accepted address is latched into `req_addr`.
- Hit (IDLE, accepted, line valid and tag match):
  - Next cycle: `valid_to_if`=1, `inst_to_if`=data[index].
  - State stays IDLE.
- Miss (IDLE, accepted, no match):
  - State goes to MISS.
  - Next cycle: `valid_to_memctrl`=1, `addr_to_memctrl`={req_addr[31:2],2'b00}.
  - Both are held unchanged until `valid_from_memctrl` is seen. The memory controller samples the request level only while it is idle, so the request must not drop early.
- Fill (MISS or DROP, `valid_from_memctrl`=1 in cycle m):
  - Write data, tag, and valid[index] from `req_addr`.
  - `valid_to_memctrl`<=0 at m+1.
  - From MISS: `valid_to_if`=1 and `inst_to_if`=fill data at m+1.
  - From DROP: no response.
  - State goes to IDLE at m+1.
- `clear` in cycle t:
  - `valid_to_if` is 0 at t+1, even if a hit response was due.
  - MISS goes to DROP. The memory request cannot be cancelled and stays held.
  - IDLE stays IDLE.
  - A fill in the same cycle as `clear` still installs the line and returns to IDLE, with no response.
- Requests during MISS/DROP are ignored because `ready_to_if`=0.
- `valid_from_memctrl` while IDLE is ignored.

## Timing
- Reset values (at the cycle after `rst`): state IDLE, all valid bits 0, `valid_to_if`=0, `inst_to_if`=0, `valid_to_memctrl`=0, `addr_to_memctrl`=0.
- Reset mid-miss: abandon the fill, drop the request next cycle, and ignore the later `valid_from_memctrl`.
- `rst` has priority over `rdy`. `rdy` low holds every register, including a held memory request.
- Hit latency: 1 cycle from acceptance to `valid_to_if`.
- Miss latency: 1 cycle to `valid_to_memctrl`, then memory-controller time, then 1 cycle from `valid_from_memctrl` to `valid_to_if`.
- Back-to-back:
  - A new request may be accepted in the same cycle `valid_to_if` is high, since state is IDLE.
  - Hits therefore sustain one per cycle.
  - A new miss may reassert `valid_to_memctrl` at m+2. The memory controller is in its one-cycle stall at m+1, so this is safe.
- `valid_to_if` and `valid_from_memctrl` are pulses.

## Test plan
- Cold miss:
  - Stimulus: after reset, fetch 0x00000004 at t; memctrl returns 0x00500093 at m.
  - Required: `valid_to_memctrl`=1 and `addr_to_memctrl`=0x4 from t+1 to m; `valid_to_if`=1 with inst 0x00500093 at m+1; `valid_to_memctrl`=0 at m+1.
- Hit:
  - Stimulus: refetch 0x00000004.
  - Required: `valid_to_if` at t+1 with 0x00500093; `valid_to_memctrl` never rises.
  - Stimulus: 8 consecutive cycles of hits.
  - Required: 8 consecutive response pulses.
- Conflict (INDEX_BITS=6):
  - Stimulus: fetch 0x00000104 (same index, different tag).
  - Required: miss with `addr_to_memctrl`=0x104, line replaced.
  - Stimulus: fetch 0x00000004 again.
  - Required: miss again.
- Flush during miss:
  - Stimulus: fetch 0x00000040 (miss), `clear` 3 cycles later, fill 0x12345678 at m.
  - Required: no `valid_to_if`; `ready_to_if`=0 until m+1.
  - Stimulus: refetch 0x00000040.
  - Required: hit returning 0x12345678.
- `rdy` stall and simultaneous events:
  - Stimulus: `rdy`=0 for 5 cycles mid-miss with `valid_from_memctrl` held low.
  - Required: all outputs unchanged.
  - Stimulus: `clear` and `valid_from_memctrl` in the same cycle.
  - Required: no response, state IDLE, line installed.
- Reset mid-miss:
  - Stimulus: `rst` while in MISS for address 0x4 (previously cached).
  - Required: outputs 0 next cycle; a later stray `valid_from_memctrl` is ignored; fetching 0x4 misses.
